vga_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 three-bar VGA test-pattern controller.
- Generates HS/VS/BLANK from fully parametrised timing with selectable sync polarity.
- Produces one of four run-time-selectable test patterns (vertical bars, horizontal bars, checkerboard, solid colour) and exports aligned pixel coordinates plus a frame counter.
- Sits between the pixel-clock PLL and the DAC/VGA pins; also used as bring-up source for downstream frame-buffer work.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_pattern_gen_if.sv | 28 ++
 rtl/vga_timing_counter.sv | 54 +++++
 rtl/vga_pattern_gen.sv | 181 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 136 +++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: default 640x480@60 timing,
// pattern mode encodings and the 8-colour bar palette.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_VBAR  = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } vga_mode_e;

    // One bit per channel; expanded to full channel width by the user.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } pal_rgb_t;

    localparam pal_rgb_t PAL_WHITE   = 3'b111;
    localparam pal_rgb_t PAL_YELLOW  = 3'b110;
    localparam pal_rgb_t PAL_CYAN    = 3'b011;
    localparam pal_rgb_t PAL_GREEN   = 3'b010;
    localparam pal_rgb_t PAL_MAGENTA = 3'b101;
    localparam pal_rgb_t PAL_RED     = 3'b100;
    localparam pal_rgb_t PAL_BLUE    = 3'b001;
    localparam pal_rgb_t PAL_BLACK   = 3'b000;

    function automatic pal_rgb_t palette(input logic [2:0] idx);
        pal_rgb_t c;
        c = PAL_BLACK;
        case (idx)
            3'd0: c = PAL_WHITE;
            3'd1: c = PAL_YELLOW;
            3'd2: c = PAL_CYAN;
            3'd3: c = PAL_GREEN;
            3'd4: c = PAL_MAGENTA;
            3'd5: c = PAL_RED;
            3'd6: c = PAL_BLUE;
            default: c = PAL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator: syncs, blanking, colour,
// aligned pixel coordinates and frame events.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic               oHS;
    logic               oVS;
    logic               oBLANK_n;
    logic [COLOR_W-1:0] oVGA_R;
    logic [COLOR_W-1:0] oVGA_G;
    logic [COLOR_W-1:0] oVGA_B;
    logic [X_W-1:0]     oX;
    logic [Y_W-1:0]     oY;
    logic               oFRAME_START;
    logic [15:0]        oFRAME_CNT;

    modport master (
        output oHS, oVS, oBLANK_n, oVGA_R, oVGA_G, oVGA_B,
        output oX, oY, oFRAME_START, oFRAME_CNT
    );

    modport slave (
        input oHS, oVS, oBLANK_n, oVGA_R, oVGA_G, oVGA_B,
        input oX, oY, oFRAME_START, oFRAME_CNT
    );
endinterface

// File: rtl/vga_timing_counter.sv
// Raster h/v counters with combinational active/sync decode and line/frame
// end strobes; counting is held while en is low.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          iVGA_CLK,
    input  logic          iRST_n,
    input  logic          en,
    output logic [XW-1:0] hCnt,
    output logic [YW-1:0] vCnt,
    output logic          active,
    output logic          hsAct,
    output logic          vsAct,
    output logic          lineEnd,
    output logic          frameEnd
);
    logic [31:0] hInt, vInt;

    assign hInt     = 32'(hCnt);
    assign vInt     = 32'(vCnt);
    assign lineEnd  = en && (hCnt == XW'(H_TOTAL - 1));
    assign frameEnd = lineEnd && (vCnt == YW'(V_TOTAL - 1));

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (lineEnd) begin
            hCnt <= '0;
            vCnt <= frameEnd ? '0 : vCnt + 1'b1;
        end else if (en) begin
            hCnt <= hCnt + 1'b1;
        end
    end

    // 32-bit compares so a sync window ending exactly at H_TOTAL cannot overflow XW.
    assign active = (32'(H_ACTIVE) > hInt) && (32'(V_ACTIVE) > vInt);
    assign hsAct  = (32'(H_ACTIVE + H_FP) <= hInt) && (32'(H_ACTIVE + H_FP + H_SYNC) > hInt);
    assign vsAct  = (32'(V_ACTIVE + V_FP) <= vInt) && (32'(V_ACTIVE + V_FP + V_SYNC) > vInt);

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern source: timing counter, frame-latched mode,
// bar/checker/solid pattern pipeline and frame counter; 2-cycle pin latency.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST_n,
    input  logic [1:0]           iMODE,
    input  logic [3*COLOR_W-1:0] iSOLID_RGB,
    vga_pattern_gen_if.master    vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int HBW     = H_ACTIVE / NUM_BARS;
    localparam int VBW     = V_ACTIVE / NUM_BARS;
    localparam int STAGES  = 1;

    typedef struct packed {
        logic                 active;
        logic                 hs;
        logic                 vs;
        logic                 fs;
        logic [XW-1:0]        x;
        logic [YW-1:0]        y;
        logic [3*COLOR_W-1:0] rgb;
    } s1_t;

    logic [STAGES:0]      vldPipe;
    logic [XW-1:0]        hCnt, hBarCnt;
    logic [YW-1:0]        vCnt, vBarCnt;
    logic [2:0]           hBarIdx, vBarIdx;
    logic                 tActive, tHs, tVs, lineEnd, frameEnd;
    vga_mode_e            modeR;
    logic [3*COLOR_W-1:0] solidR, patRgb;
    s1_t                  s1;
    logic                 seenFrame, outActive;
    logic [15:0]          frameCnt;

    function automatic logic [3*COLOR_W-1:0] expand(input pal_rgb_t p);
        return {{COLOR_W{p.r}}, {COLOR_W{p.g}}, {COLOR_W{p.b}}};
    endfunction

    // vldPipe[0] holds the counters for one cycle after release so pixel
    // (0,0) leaves on the third edge; later bits qualify the later stages.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) vldPipe <= '0;
        else         vldPipe <= {vldPipe[STAGES-1:0], 1'b1};
    end

    vga_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) uTiming (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .en       (vldPipe[0]),
        .hCnt     (hCnt),
        .vCnt     (vCnt),
        .active   (tActive),
        .hsAct    (tHs),
        .vsAct    (tVs),
        .lineEnd  (lineEnd),
        .frameEnd (frameEnd)
    );

    // Bar indices track the counters with in-bar counters instead of a divider;
    // they saturate at the last bar through blanking.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            hBarCnt <= '0;
            hBarIdx <= '0;
            vBarCnt <= '0;
            vBarIdx <= '0;
        end else if (lineEnd) begin
            hBarCnt <= '0;
            hBarIdx <= '0;
            if (frameEnd) begin
                vBarCnt <= '0;
                vBarIdx <= '0;
            end else if (vBarCnt == YW'(VBW - 1)) begin
                vBarCnt <= '0;
                if (vBarIdx != 3'(NUM_BARS - 1)) vBarIdx <= vBarIdx + 3'd1;
            end else begin
                vBarCnt <= vBarCnt + 1'b1;
            end
        end else if (vldPipe[0]) begin
            if (hBarCnt == XW'(HBW - 1)) begin
                hBarCnt <= '0;
                if (hBarIdx != 3'(NUM_BARS - 1)) hBarIdx <= hBarIdx + 3'd1;
            end else begin
                hBarCnt <= hBarCnt + 1'b1;
            end
        end
    end

    // Latching on the last counter position means the whole next frame,
    // starting at (0,0), sees one consistent mode.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            modeR  <= MODE_VBAR;
            solidR <= '0;
        end else if (frameEnd) begin
            modeR  <= vga_mode_e'(iMODE);
            solidR <= iSOLID_RGB;
        end
    end

    always_comb begin
        patRgb = '0;
        case (modeR)
            MODE_VBAR:  patRgb = expand(palette(hBarIdx));
            MODE_HBAR:  patRgb = expand(palette(vBarIdx));
            MODE_CHECK: patRgb = expand((hCnt[CHECK_LOG2] ^ vCnt[CHECK_LOG2]) ? PAL_WHITE : PAL_BLACK);
            default:    patRgb = solidR;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            s1 <= '0;
        end else begin
            s1.active <= vldPipe[0] & tActive;
            s1.hs     <= vldPipe[0] & tHs;
            s1.vs     <= vldPipe[0] & tVs;
            s1.fs     <= vldPipe[0] && (hCnt == '0) && (vCnt == '0);
            s1.x      <= hCnt;
            s1.y      <= vCnt;
            s1.rgb    <= patRgb;
        end
    end

    assign outActive = s1.active & vldPipe[1];

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            vga.oHS          <= ~HS_POL;
            vga.oVS          <= ~VS_POL;
            vga.oBLANK_n     <= 1'b0;
            vga.oVGA_R       <= '0;
            vga.oVGA_G       <= '0;
            vga.oVGA_B       <= '0;
            vga.oX           <= '0;
            vga.oY           <= '0;
            vga.oFRAME_START <= 1'b0;
            frameCnt         <= '0;
            seenFrame        <= 1'b0;
        end else begin
            vga.oHS          <= HS_POL ? s1.hs : ~s1.hs;
            vga.oVS          <= VS_POL ? s1.vs : ~s1.vs;
            vga.oBLANK_n     <= outActive;
            {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B} <= outActive ? s1.rgb : '0;
            vga.oX           <= s1.x;
            vga.oY           <= s1.y;
            vga.oFRAME_START <= s1.fs;
            // The first frame after reset keeps the count at 0.
            if (s1.fs) begin
                seenFrame <= 1'b1;
                if (seenFrame) frameCnt <= frameCnt + 16'd1;
            end
        end
    end

    assign vga.oFRAME_CNT = frameCnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Drives two generators (active-low and active-high sync) with a small raster
// and compares every output cycle against a position-based reference model.
module tb_vga_pattern_gen;
    localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int NB = 8, CL = 2;

    logic        clk, rstN;
    logic [1:0]  mode;
    logic [11:0] solid;
    int          k, nChecks, nPass;
    logic [1:0]  modeHist  [0:32767];
    logic [11:0] solidHist [0:32767];
    logic [11:0] palTab    [0:7];

    vga_pattern_gen_if #(.COLOR_W(4), .X_W(6), .Y_W(5)) vif0 ();
    vga_pattern_gen_if #(.COLOR_W(4), .X_W(6), .Y_W(5)) vif1 ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .NUM_BARS(NB), .CHECK_LOG2(CL)
    ) dut0 (.iVGA_CLK(clk), .iRST_n(rstN), .iMODE(mode), .iSOLID_RGB(solid), .vga(vif0));

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .NUM_BARS(NB), .CHECK_LOG2(CL)
    ) dut1 (.iVGA_CLK(clk), .iRST_n(rstN), .iMODE(mode), .iSOLID_RGB(solid), .vga(vif1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

    // Expected outputs after posedge kk since release: pixel p = kk-3 in raster order.
    function automatic logic [63:0] expVec(input int kk, input bit pol);
        int p, x, y, f, m;
        logic [11:0] rgb, sol;
        logic hs, vs, act, fs;
        if (kk < 3) return {21'b0, ~pol, ~pol, 1'b0, 12'h0, 6'd0, 5'd0, 1'b0, 16'd0};
        p   = kk - 3;
        x   = p % HT;
        y   = (p / HT) % VT;
        f   = p / FT;
        act = (x < HA) && (y < VA);
        hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
        vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
        fs  = (x == 0) && (y == 0);
        m   = (f == 0) ? 0 : int'(modeHist[f * FT + 1]);
        sol = (f == 0) ? 12'h0 : solidHist[f * FT + 1];
        rgb = 12'h0;
        if (act) begin
            case (m)
                0:       rgb = palTab[x / (HA / NB)];
                1:       rgb = palTab[y / (VA / NB)];
                2:       rgb = (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 12'hFFF : 12'h000;
                default: rgb = sol;
            endcase
        end
        return {21'b0, pol ? hs : ~hs, pol ? vs : ~vs, act, rgb, 6'(x), 5'(y), fs, 16'(f)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s k=%0d got=%h want=%h", tag, k, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstN) k = 0;
        else       k = k + 1;
        modeHist[k]  = mode;
        solidHist[k] = solid;
        @(negedge clk);
        chk("pins_pol0", {21'b0, vif0.oHS, vif0.oVS, vif0.oBLANK_n, vif0.oVGA_R, vif0.oVGA_G,
                          vif0.oVGA_B, vif0.oX, vif0.oY, vif0.oFRAME_START, vif0.oFRAME_CNT},
            expVec(k, 1'b0));
        chk("pins_pol1", {21'b0, vif1.oHS, vif1.oVS, vif1.oBLANK_n, vif1.oVGA_R, vif1.oVGA_G,
                          vif1.oVGA_B, vif1.oX, vif1.oY, vif1.oFRAME_START, vif1.oFRAME_CNT},
            expVec(k, 1'b1));
    endtask

    task automatic runTo(input int target);
        while (k < target) tick();
    endtask

    initial begin
        palTab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        nChecks = 0;
        nPass   = 0;
        k       = 0;
        rstN    = 1'b0;
        mode    = 2'd0;
        solid   = 12'h000;
        repeat (3) tick();
        rstN = 1'b1;

        // Bars for two frames, then switch to checker mid-frame.
        runTo(2 * FT + 3);
        runTo(2 * FT + 8 * HT + 3);
        mode = 2'd2;
        runTo(4 * FT + 13);

        // Solid colour over several frames.
        mode  = 2'd3;
        solid = 12'hA5C;
        runTo(8 * FT + 5 * HT + 23);

        // One-cycle reset mid-frame, then restart.
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        runTo(2 * FT + 3);

        // Random mode/colour changes, biased around the latch point.
        while (k < 14 * FT) begin
            tick();
            if ((((k + 1) % FT) <= 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                mode  = 2'($urandom_range(0, 3));
                solid = 12'($urandom);
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
